// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
//   Shared constants, state encoding and CMD field positions for the UART
//   command responder.
//   Optional feature macro: UART_CMD_CSUM_EN (adds a trailing checksum byte).
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // CMD byte layout: [7] write, [6:4] reserved (must be 0), [3:0] address
  localparam int CMD_W_BIT   = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_DATA    = 4'd2,
    ST_CSUM    = 4'd3,
    ST_EXEC    = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_TX_ACK  = 4'd6,
    ST_TX_DATA = 4'd7,
    ST_TX_NAK  = 4'd8
  } state_e;

  // Checksum over the packet; DATA is 0 for reads.
  function automatic logic [7:0] calc_csum(input logic [7:0] cmd, input logic [7:0] data);
    return SYNC_BYTE ^ cmd ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// uart_cmd_timeout
//   Tick-driven inter-byte silence counter. Counts baud ticks while enabled,
//   clears on request, and flags expiry once TIMEOUT_TICKS ticks have elapsed.
//   Ports:
//     clk, reset_n (async, active-high despite the name), tick (baud tick),
//     clr (synchronous clear, highest priority), en (count enable),
//     expired (counter has reached TIMEOUT_TICKS).
module uart_cmd_timeout #(
  parameter int TIMEOUT_TICKS = 2560,
  parameter int TO_W          = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  assign expired = (r_cnt == TO_W'(TIMEOUT_TICKS));

  // Counter parks at the limit so expiry stays asserted until cleared.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                      r_cnt <= '0;
    else if (clr)                     r_cnt <= '0;
    else if (en && tick && !expired)  r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Responder for the host register link. Pops bytes from the UART RX buffer,
//   parses SYNC/CMD/[DATA]/[CSUM] packets, drives a 16-entry register port
//   and pushes ACK / read data / NAK bytes into the UART TX buffer.
//   Optional feature macro: UART_CMD_CSUM_EN (checksum byte required/checked).
//   Ports:
//     clk, reset_n          clock, async active-high reset
//     tick                  baud tick (16x oversample), drives the timeout
//     r_data/rx_empty       RX buffer head / empty flag; rd_uart pops
//     w_data/wr_uart        TX byte / push strobe; tx_full backpressure
//     reg_addr/reg_wdata    register port address / write data
//     reg_we/reg_re         one-cycle write / read strobes
//     reg_rdata             read data, valid the cycle after reg_re
//     busy                  any state other than IDLE
//     nak_cnt               saturating count of NAKs sent
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 2560,
  parameter int TO_W          = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       rd_uart,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic       tx_full,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] nak_cnt
);

  state_e     r_state;
  logic       r_is_wr;
  logic [7:0] r_hold;

  logic w_parse;
  logic w_tx;
  logic w_pop;
  logic w_push;
  logic w_expired;
  logic w_to_clr;

  assign w_parse = (r_state == ST_CMD) || (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign w_tx    = (r_state == ST_TX_ACK) || (r_state == ST_TX_DATA) || (r_state == ST_TX_NAK);

  // Pop/push strobes are the registered state qualified by the live buffer
  // flags: that is what lets a full RX buffer drain one byte per cycle while
  // never popping an empty buffer or pushing into a full one. Pop and push
  // belong to disjoint states, so they can never coincide.
  assign w_pop   = !reset_n && !rx_empty &&
                   ((r_state == ST_IDLE) || (w_parse && !w_expired));
  assign w_push  = w_tx && !tx_full;
  assign rd_uart = w_pop;
  assign wr_uart = w_push;

  assign w_to_clr = w_pop || (r_state == ST_IDLE) || w_expired;

  uart_cmd_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .clr     (w_to_clr),
    .en      (w_parse),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state   <= ST_IDLE;
      r_is_wr   <= 1'b0;
      r_hold    <= 8'h00;
      w_data    <= 8'h00;
      reg_addr  <= 4'h0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      nak_cnt   <= 8'h00;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Anything but SYNC is dropped silently.
          if (w_pop && r_data == SYNC_BYTE) begin
            r_state <= ST_CMD;
            busy    <= 1'b1;
          end
        end

        ST_CMD: begin
          if (w_expired) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_pop) begin
            r_is_wr  <= r_data[CMD_W_BIT];
            reg_addr <= r_data[CMD_ADDR_HI:CMD_ADDR_LO];
            if (r_data[CMD_RSV_HI:CMD_RSV_LO] != 3'b000) begin
              r_state <= ST_TX_NAK;
              w_data  <= NAK_BYTE;
            end else if (r_data[CMD_W_BIT]) begin
              r_state <= ST_DATA;
            end else begin
`ifdef UART_CMD_CSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_EXEC;
              reg_re  <= 1'b1;
`endif
            end
          end
        end

        ST_DATA: begin
          if (w_expired) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_pop) begin
            reg_wdata <= r_data;
`ifdef UART_CMD_CSUM_EN
            r_state   <= ST_CSUM;
`else
            r_state   <= ST_EXEC;
            reg_we    <= 1'b1;
`endif
          end
        end

`ifdef UART_CMD_CSUM_EN
        ST_CSUM: begin
          if (w_expired) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_pop) begin
            // Reserved bits are known to be zero here, so CMD is rebuilt
            // from the stored direction and address.
            if (r_data == calc_csum({r_is_wr, 3'b000, reg_addr},
                                    r_is_wr ? reg_wdata : 8'h00)) begin
              r_state <= ST_EXEC;
              reg_we  <= r_is_wr;
              reg_re  <= !r_is_wr;
            end else begin
              r_state <= ST_TX_NAK;
              w_data  <= NAK_BYTE;
            end
          end
        end
`endif

        // reg_we / reg_re were raised on entry, so they are high in this cycle.
        ST_EXEC: begin
          if (r_is_wr) begin
            r_state <= ST_TX_ACK;
            w_data  <= ACK_BYTE;
          end else begin
            r_state <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          r_hold  <= reg_rdata;
          r_state <= ST_TX_ACK;
          w_data  <= ACK_BYTE;
        end

        ST_TX_ACK: begin
          if (w_push) begin
            if (r_is_wr) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= ST_TX_DATA;
              w_data  <= r_hold;
            end
          end
        end

        ST_TX_DATA: begin
          if (w_push) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_TX_NAK: begin
          if (w_push) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            if (nak_cnt != 8'hFF) nak_cnt <= nak_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] nak_cnt;

  logic [7:0]  rf [16];
  logic [7:0]  rxq [$];
  logic [7:0]  exp_tx [$];
  logic [11:0] exp_wr [$];
  logic [3:0]  exp_rd [$];
  int          pop_cyc [$];
  int          push_cyc [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          nak_exp = 0;
  int          tick_div = 16;
  logic        pop_pend = 1'b0;

  always #5 clk = ~clk;

  assign reg_rdata = rf[reg_addr];

  uart_cmd_responder dut (
    .clk       (clk),
    .reset_n   (rst),
    .tick      (tick),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rd_uart   (rd_uart),
    .w_data    (w_data),
    .wr_uart   (wr_uart),
    .tx_full   (tx_full),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nak_cnt   (nak_cnt)
  );

  // Baud tick, one clk wide every tick_div cycles.
  always @(posedge clk) begin
    #2;
    tick = (tick_div == 1) || ((cyc % tick_div) == 0);
  end

  // RX buffer model: a pop seen at the negedge is applied just after the edge.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      rxq.delete(0);
      pop_pend = 1'b0;
    end
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  end

  // Scoreboard: compare every DUT strobe against the expectation queues.
  always @(negedge clk) begin
    logic [7:0]  e8;
    logic [11:0] e12;
    logic [3:0]  e4;
    cyc = cyc + 1;
    if (rd_uart) begin
      n_chk++;
      if (rx_empty) begin n_fail++; $display("FAIL pop_empty: rd_uart=1 while rx_empty=1 at cyc %0d", cyc); end
      pop_pend = 1'b1;
      pop_cyc.push_back(cyc);
    end
    if (rd_uart && wr_uart) begin
      n_fail++; $display("FAIL pop_push_same: both strobes at cyc %0d", cyc);
    end
    if (wr_uart) begin
      n_chk++;
      push_cyc.push_back(cyc);
      if (tx_full) begin
        n_fail++; $display("FAIL push_full: wr_uart=1 while tx_full=1 at cyc %0d", cyc);
      end else if (exp_tx.size() == 0) begin
        n_fail++; $display("FAIL tx_unexpected: got %02h, expected nothing", w_data);
      end else begin
        e8 = exp_tx.pop_front();
        if (w_data !== e8) begin n_fail++; $display("FAIL tx_byte: got %02h, expected %02h", w_data, e8); end
      end
    end
    if (reg_we) begin
      n_chk++;
      if (exp_wr.size() == 0) begin
        n_fail++; $display("FAIL we_unexpected: addr %0h data %02h", reg_addr, reg_wdata);
      end else begin
        e12 = exp_wr.pop_front();
        if ({reg_addr, reg_wdata} !== e12) begin
          n_fail++; $display("FAIL reg_write: got %03h, expected %03h", {reg_addr, reg_wdata}, e12);
        end
      end
    end
    if (reg_re) begin
      n_chk++;
      if (exp_rd.size() == 0) begin
        n_fail++; $display("FAIL re_unexpected: addr %0h", reg_addr);
      end else begin
        e4 = exp_rd.pop_front();
        if (reg_addr !== e4) begin n_fail++; $display("FAIL reg_read_addr: got %0h, expected %0h", reg_addr, e4); end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rxq.push_back(b);
    rx_empty = 1'b0;
    r_data   = rxq[0];
  endtask

  task automatic wr_pkt(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] c;
    c = {4'b1000, a};
    rx_push(8'hA5); rx_push(c); rx_push(d);
`ifdef UART_CMD_CSUM_EN
    rx_push(8'hA5 ^ c ^ d);
`endif
    exp_wr.push_back({a, d});
    exp_tx.push_back(8'h06);
  endtask

  task automatic rd_pkt(input logic [3:0] a);
    logic [7:0] c;
    c = {4'b0000, a};
    rx_push(8'hA5); rx_push(c);
`ifdef UART_CMD_CSUM_EN
    rx_push(8'hA5 ^ c);
`endif
    exp_rd.push_back(a);
    exp_tx.push_back(8'h06);
    exp_tx.push_back(rf[a]);
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
            rxq.size() != 0 || busy !== 1'b0) && k < budget) begin
      step(1);
      k++;
    end
    step(4);
    n_chk++;
    if (k >= budget)
      begin n_fail++; $display("FAIL %s_drain: tx %0d wr %0d rd %0d rx %0d left, expected 0", nm,
                               exp_tx.size(), exp_wr.size(), exp_rd.size(), rxq.size()); end
  endtask

  task automatic clear_log();
    pop_cyc.delete();
    push_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_chk++;
    if ({rd_uart, wr_uart, w_data, reg_we, reg_re, reg_addr, reg_wdata, busy, nak_cnt} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: w_data %02h addr %0h wdata %02h busy %b nak %0d, expected all 0",
                               w_data, reg_addr, reg_wdata, busy, nak_cnt); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_write();
    int np;
    clear_log();
    wr_pkt(4'h3, 8'h5C);
    drain("write", 200);
    np = pop_cyc.size();
    n_chk++;
    if (np < 3 || push_cyc.size() != 1) begin
      n_fail++; $display("FAIL write_counts: pops %0d pushes %0d, expected >=3 and 1", np, push_cyc.size());
    end else begin
      n_chk++;
      if (push_cyc[0] - pop_cyc[np-1] != 2)
        begin n_fail++; $display("FAIL write_latency: got %0d, expected 2", push_cyc[0] - pop_cyc[np-1]); end
      n_chk++;
      if (pop_cyc[np-1] - pop_cyc[0] != np - 1)
        begin n_fail++; $display("FAIL write_rate: %0d cycles for %0d pops, expected %0d", pop_cyc[np-1] - pop_cyc[0], np, np - 1); end
    end
  endtask

  task automatic test_read();
    int np;
    rf[7] = 8'hC3;
    clear_log();
    rd_pkt(4'h7);
    drain("read", 200);
    np = pop_cyc.size();
    n_chk++;
    if (np < 2 || push_cyc.size() != 2) begin
      n_fail++; $display("FAIL read_counts: pops %0d pushes %0d, expected >=2 and 2", np, push_cyc.size());
    end else begin
      n_chk++;
      if (push_cyc[0] - pop_cyc[np-1] != 3)
        begin n_fail++; $display("FAIL read_latency: got %0d, expected 3", push_cyc[0] - pop_cyc[np-1]); end
      n_chk++;
      if (push_cyc[1] - push_cyc[0] != 1)
        begin n_fail++; $display("FAIL read_data_gap: got %0d, expected 1", push_cyc[1] - push_cyc[0]); end
    end
  endtask

  task automatic test_garbage();
    clear_log();
    rx_push(8'h11); rx_push(8'h22);
    wr_pkt(4'h0, 8'h01);
    drain("garbage", 200);
    n_chk++;
    if (push_cyc.size() != 1)
      begin n_fail++; $display("FAIL garbage_pushes: got %0d, expected 1", push_cyc.size()); end
  endtask

  task automatic test_nak();
    rx_push(8'hA5); rx_push(8'h90);
    exp_tx.push_back(8'h15); nak_exp++;
    rx_push(8'hA5); rx_push(8'h30);
    exp_tx.push_back(8'h15); nak_exp++;
`ifdef UART_CMD_CSUM_EN
    rx_push(8'hA5); rx_push(8'h83); rx_push(8'h5C); rx_push(8'h00);
    exp_tx.push_back(8'h15); nak_exp++;
`endif
    drain("nak", 300);
    n_chk++;
    if (nak_cnt !== 8'(nak_exp))
      begin n_fail++; $display("FAIL nak_count: got %0d, expected %0d", nak_cnt, nak_exp); end
  endtask

  task automatic test_nak_sat();
    for (int i = 0; i < 300; i++) begin
      rx_push(8'hA5); rx_push(8'h90);
      exp_tx.push_back(8'h15);
      if (nak_exp < 255) nak_exp++;
    end
    drain("nak_sat", 5000);
    n_chk++;
    if (nak_cnt !== 8'd255)
      begin n_fail++; $display("FAIL nak_saturate: got %0d, expected 255", nak_cnt); end
  endtask

  task automatic test_backpressure();
    rf[9] = 8'h5A;
    tx_full = 1'b1;
    clear_log();
    rd_pkt(4'h9);
    rx_push(8'h33);
    step(50);
    n_chk++;
    if (push_cyc.size() != 0)
      begin n_fail++; $display("FAIL bp_no_push: got %0d pushes, expected 0", push_cyc.size()); end
    n_chk++;
    if (rxq.size() != 1)
      begin n_fail++; $display("FAIL bp_no_pop: rx holds %0d, expected 1", rxq.size()); end
    n_chk++;
    if (busy !== 1'b1)
      begin n_fail++; $display("FAIL bp_busy: got %b, expected 1", busy); end
    tx_full = 1'b0;
    drain("bp", 200);
    n_chk++;
    if (push_cyc.size() != 2)
      begin n_fail++; $display("FAIL bp_pushes: got %0d, expected 2", push_cyc.size()); end
  endtask

  task automatic test_timeout();
    clear_log();
    tick_div = 1;
    rx_push(8'hA5);
    step(2500);
    n_chk++;
    if (busy !== 1'b1)
      begin n_fail++; $display("FAIL timeout_early: busy %b, expected 1", busy); end
    step(100);
    n_chk++;
    if (busy !== 1'b0)
      begin n_fail++; $display("FAIL timeout_idle: busy %b, expected 0", busy); end
    n_chk++;
    if (push_cyc.size() != 0)
      begin n_fail++; $display("FAIL timeout_silent: got %0d pushes, expected 0", push_cyc.size()); end
    tick_div = 16;
    wr_pkt(4'h5, 8'hAA);
    drain("timeout_next", 200);
  endtask

  task automatic test_reset_mid();
    clear_log();
    rx_push(8'hA5); rx_push(8'h83);
    step(5);
    n_chk++;
    if (busy !== 1'b1)
      begin n_fail++; $display("FAIL midrst_busy: got %b, expected 1", busy); end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({rd_uart, wr_uart, w_data, reg_we, reg_re, reg_addr, reg_wdata, busy, nak_cnt} !== '0)
      begin n_fail++; $display("FAIL midrst_outputs: addr %0h busy %b nak %0d, expected all 0",
                               reg_addr, busy, nak_cnt); end
    nak_exp = 0;
    step(2);
    rst = 1'b0;
    rx_push(8'h5C);
    step(20);
    n_chk++;
    if (push_cyc.size() != 0 || busy !== 1'b0 || rxq.size() != 0)
      begin n_fail++; $display("FAIL midrst_after: pushes %0d busy %b rx %0d, expected 0 0 0",
                               push_cyc.size(), busy, rxq.size()); end
  endtask

  task automatic test_back_to_back();
    rf[2] = 8'h7E;
    clear_log();
    wr_pkt(4'hC, 8'h91);
    rd_pkt(4'h2);
    wr_pkt(4'hF, 8'h00);
    drain("b2b", 300);
    n_chk++;
    if (push_cyc.size() != 4)
      begin n_fail++; $display("FAIL b2b_pushes: got %0d, expected 4", push_cyc.size()); end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'(i * 17);
    test_reset();
    test_write();
    test_read();
    test_garbage();
    test_nak();
    test_nak_sat();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
